// File: rtl/mseq_pkg.sv
// Shared types and constants for the M-sequence word generator.
// Tap masks use bit i for lfsr[i], so x^n + x^k + 1 sets bits n-1 and k-1.
package mseq_pkg;

    typedef enum logic [0:0] {RUN, FAULT} mseq_state_e;

    localparam logic [3:0]  P4  = 4'hC;
    localparam logic [4:0]  P5  = 5'h14;
    localparam logic [5:0]  P6  = 6'h30;
    localparam logic [6:0]  P7  = 7'h60;
    localparam logic [7:0]  P8  = 8'hB8;
    localparam logic [8:0]  P9  = 9'h110;
    localparam logic [9:0]  P10 = 10'h240;
    localparam logic [10:0] P11 = 11'h500;
    localparam logic [11:0] P12 = 12'h829;
    localparam logic [12:0] P13 = 13'h100D;
    localparam logic [13:0] P14 = 14'h2015;
    localparam logic [14:0] P15 = 15'h6000;
    localparam logic [15:0] P16 = 16'hD008;
    localparam logic [16:0] P17 = 17'h12000;
    localparam logic [17:0] P18 = 18'h20400;
    localparam logic [18:0] P19 = 19'h40023;
    localparam logic [19:0] P20 = 20'h90000;
    localparam logic [20:0] P21 = 21'h140000;
    localparam logic [21:0] P22 = 22'h300000;
    localparam logic [22:0] P23 = 23'h420000;
    localparam logic [23:0] P24 = 24'hE10000;
    localparam logic [24:0] P25 = 25'h1200000;
    localparam logic [25:0] P26 = 26'h2000023;
    localparam logic [26:0] P27 = 27'h4000013;
    localparam logic [27:0] P28 = 28'h9000000;
    localparam logic [28:0] P29 = 29'h14000000;
    localparam logic [29:0] P30 = 30'h20000029;
    localparam logic [30:0] P31 = 31'h48000000;
    localparam logic [31:0] P32 = 32'h80200003;

    // One spare bit so the saturating step counter can exceed any real period.
    function automatic int unsigned period_cnt_width(input int unsigned order);
        return order + 1;
    endfunction

endpackage

// File: rtl/mseq_lfsr_core.sv
// Fibonacci LFSR with run-time tap mask and seed; reports its output bit and
// whether the next state returns to the loaded seed.
module mseq_lfsr_core
    import mseq_pkg::*;
#(
    parameter int unsigned      ORDER = 7,
    parameter logic [ORDER-1:0] POLY  = P7,
    parameter logic [ORDER-1:0] SEED  = 7'h01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             load,
    input  logic [ORDER-1:0] cfg_poly,
    input  logic [ORDER-1:0] cfg_seed,
    output logic             out_bit,
    output logic             next_match
);

    if (ORDER < 2 || ORDER > 32) begin : g_bad_order
        $error("mseq_lfsr_core: ORDER must be in 2..32");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("mseq_lfsr_core: SEED must be nonzero");
    end

    logic [ORDER-1:0] lfsr_q, poly_q, seed_q, lfsr_next;

    assign lfsr_next  = {lfsr_q[ORDER-2:0], ^(lfsr_q & poly_q)};
    assign out_bit    = lfsr_q[ORDER-1];
    assign next_match = (lfsr_next == seed_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
            poly_q <= POLY;
            seed_q <= SEED;
        end else if (load) begin
            lfsr_q <= cfg_seed;
            poly_q <= cfg_poly;
            seed_q <= cfg_seed;
        end else if (step) begin
            lfsr_q <= lfsr_next;
        end
    end

endmodule

// File: rtl/mseq_word_gen.sv
// M-sequence generator: packs LFSR bits MSB-first into words behind a
// valid/ready handshake, tracks the sequence period and flags a zero seed.
module mseq_word_gen
    import mseq_pkg::*;
#(
    parameter int unsigned      ORDER      = 7,
    parameter int unsigned      DATA_WIDTH = 64,
    parameter logic [ORDER-1:0] POLY       = P7,
    parameter logic [ORDER-1:0] SEED       = 7'h01
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  calcu_ctrl,
    input  logic                  cfg_load,
    input  logic [ORDER-1:0]      cfg_poly,
    input  logic [ORDER-1:0]      cfg_seed,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  period_wrap,
    output logic [ORDER:0]        period_len,
    output logic                  lock_err
);

    localparam int unsigned    CntW    = period_cnt_width(ORDER);
    localparam int unsigned    BitW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);
    localparam logic [CntW-1:0] CntMax  = '1;

    mseq_state_e           state_q;
    logic [DATA_WIDTH-1:0] word_q, word_shift;
    logic [BitW-1:0]       bit_cnt_q;
    logic [CntW-1:0]       step_cnt_q;
    logic                  out_bit, next_match, last_bit, stall, step_en;

    assign last_bit = (bit_cnt_q == LastBit);
    // Only the word-completing step can overwrite an unaccepted word, so only it stalls.
    assign stall    = last_bit && out_valid && !out_ready;
    assign step_en  = calcu_ctrl && (state_q == RUN) && !stall && !cfg_load;

    if (DATA_WIDTH == 1) begin : g_word_1
        assign word_shift = out_bit;
    end else begin : g_word_n
        assign word_shift = {word_q[DATA_WIDTH-2:0], out_bit};
    end

    mseq_lfsr_core #(
        .ORDER (ORDER),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (step_en),
        .load       (cfg_load),
        .cfg_poly   (cfg_poly),
        .cfg_seed   (cfg_seed),
        .out_bit    (out_bit),
        .next_match (next_match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            word_q      <= '0;
            bit_cnt_q   <= '0;
            step_cnt_q  <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            period_wrap <= 1'b0;
            period_len  <= '0;
            lock_err    <= 1'b0;
        end else begin
            period_wrap <= 1'b0;
            if (cfg_load) begin
                state_q    <= (cfg_seed == '0) ? FAULT : RUN;
                lock_err   <= (cfg_seed == '0);
                word_q     <= '0;
                bit_cnt_q  <= '0;
                step_cnt_q <= '0;
                out_valid  <= 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
                if (step_en) begin
                    word_q <= word_shift;
                    if (last_bit) begin
                        out_data  <= word_shift;
                        out_valid <= 1'b1;
                        bit_cnt_q <= '0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BitW'(1);
                    end
                    if (next_match) begin
                        period_wrap <= 1'b1;
                        period_len  <= step_cnt_q + CntW'(1);
                        step_cnt_q  <= '0;
                    end else if (step_cnt_q != CntMax) begin
                        step_cnt_q <= step_cnt_q + CntW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mseq_word_gen.sv
// Scoreboard bench: expected words come from an arithmetic LFSR bit-stream model;
// monitors pop and compare on every accepted word.
module tb_mseq_word_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ORDER=7, DATA_WIDTH=8 instance
    logic        rst_n7, calcu7, load7, ready7;
    logic [6:0]  poly7, seed7;
    logic [7:0]  data7;
    logic        valid7, wrap7, lock7;
    logic [7:0]  plen7;

    // ORDER=15, DATA_WIDTH=64 instance
    logic        rst_n15, calcu15, load15, ready15;
    logic [14:0] poly15, seed15;
    logic [63:0] data15;
    logic        valid15, wrap15, lock15;
    logic [15:0] plen15;

    mseq_word_gen #(
        .ORDER      (7),
        .DATA_WIDTH (8),
        .POLY       (7'h60),
        .SEED       (7'h01)
    ) dut7 (
        .clk         (clk),
        .rst_n       (rst_n7),
        .calcu_ctrl  (calcu7),
        .cfg_load    (load7),
        .cfg_poly    (poly7),
        .cfg_seed    (seed7),
        .out_data    (data7),
        .out_valid   (valid7),
        .out_ready   (ready7),
        .period_wrap (wrap7),
        .period_len  (plen7),
        .lock_err    (lock7)
    );

    mseq_word_gen #(
        .ORDER      (15),
        .DATA_WIDTH (64),
        .POLY       (15'h6000),
        .SEED       (15'h0001)
    ) dut15 (
        .clk         (clk),
        .rst_n       (rst_n15),
        .calcu_ctrl  (calcu15),
        .cfg_load    (load15),
        .cfg_poly    (poly15),
        .cfg_seed    (seed15),
        .out_data    (data15),
        .out_valid   (valid15),
        .out_ready   (ready15),
        .period_wrap (wrap15),
        .period_len  (plen15),
        .lock_err    (lock15)
    );

    int checks = 0;
    int errors = 0;

    longint unsigned q7[$];
    longint unsigned q15[$];
    longint unsigned st7, st15;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: emit dw bits of the M-sequence, MSB of the state first.
    task automatic model_word(input int order, input longint unsigned poly, input int dw,
                              inout longint unsigned st, output longint unsigned w);
        longint unsigned mask, b, fb;
        mask = (64'd1 << order) - 64'd1;
        w = 0;
        for (int i = 0; i < dw; i++) begin
            b  = (st >> (order - 1)) & 64'd1;
            fb = longint'($countones(st & poly) % 2);
            st = ((st << 1) | fb) & mask;
            w  = (w << 1) | b;
        end
    endtask

    task automatic refill7(input longint unsigned seed);
        longint unsigned w;
        q7.delete();
        st7 = seed;
        repeat (200) begin
            model_word(7, 64'h60, 8, st7, w);
            q7.push_back(w);
        end
    endtask

    task automatic refill15(input longint unsigned seed);
        longint unsigned w;
        q15.delete();
        st15 = seed;
        repeat (600) begin
            model_word(15, 64'h6000, 64, st15, w);
            q15.push_back(w);
        end
    endtask

    // Monitors: a word is consumed at the next edge when valid && ready and no load.
    always @(negedge clk) begin
        if (rst_n7 && valid7 && ready7 && !load7) begin
            if (q7.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut7_scoreboard_underflow: got word 0x%0h, expected none", data7);
            end else begin
                check("dut7_word", data7, q7.pop_front());
            end
        end
        if (rst_n15 && valid15 && ready15 && !load15) begin
            if (q15.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut15_scoreboard_underflow: got word 0x%0h, expected none",
                         data15);
            end else begin
                check("dut15_word", data15, q15.pop_front());
            end
        end
    end

    initial begin
        #950_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    int              cyc, steps, first_cyc, wrapped, flag;
    longint unsigned st_tmp, w_tmp, plen_before;

    initial begin
        rst_n7  = 1'b0; calcu7  = 1'b0; load7  = 1'b0; ready7  = 1'b0;
        poly7   = 7'h60; seed7  = 7'h01;
        rst_n15 = 1'b0; calcu15 = 1'b0; load15 = 1'b0; ready15 = 1'b0;
        poly15  = 15'h6000; seed15 = 15'h0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_data", data7, 0);
        check("rst_out_valid", valid7, 0);
        check("rst_period_wrap", wrap7, 0);
        check("rst_period_len", plen7, 0);
        check("rst_lock_err", lock7, 0);

        // Constant stepping: first word after 8 steps.
        @(posedge clk); #1;
        refill7(1);
        rst_n7 = 1'b1; calcu7 = 1'b1; ready7 = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("first_word_not_early", valid7, 0);
        @(negedge clk);
        check("first_word_valid", valid7, 1);
        check("first_word_data", data7, 8'h02);

        // Toggling calcu_ctrl, starting low.
        @(posedge clk); #1;
        rst_n7 = 1'b0; calcu7 = 1'b0; refill7(1);
        #2 rst_n7 = 1'b1;
        steps = 0; first_cyc = 0; wrapped = 0;
        for (int c = 1; c <= 400 && wrapped == 0; c++) begin
            @(posedge clk);
            if (calcu7) steps++;
            #1 calcu7 = ~calcu7;
            @(negedge clk);
            if (valid7 && first_cyc == 0) first_cyc = c;
            if (wrap7) wrapped = 1;
        end
        check("toggle_first_word_cycle", first_cyc, 16);
        check("toggle_wrap_seen", wrapped, 1);
        check("toggle_steps_at_wrap", steps, 127);
        check("toggle_period_len", plen7, 127);
        @(negedge clk);
        check("wrap_single_cycle", wrap7, 0);

        // Back-pressure: first word held, second stalls at its last bit.
        @(posedge clk); #1;
        rst_n7 = 1'b0; ready7 = 1'b0; calcu7 = 1'b1; refill7(1);
        #2 rst_n7 = 1'b1;
        for (int i = 0; i < 20 && !valid7; i++) @(negedge clk);
        check("bp_first_valid", valid7, 1);
        check("bp_first_data", data7, 8'h02);
        flag = 1;
        repeat (40) begin
            @(negedge clk);
            if (data7 !== 8'h02 || valid7 !== 1'b1) flag = 0;
        end
        check("bp_data_stable", flag, 1);
        @(posedge clk); #1 ready7 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        st_tmp = 1;
        model_word(7, 64'h60, 8, st_tmp, w_tmp);
        model_word(7, 64'h60, 8, st_tmp, w_tmp);
        check("bp_second_valid", valid7, 1);
        check("bp_second_data", data7, w_tmp);
        repeat (300) begin
            @(posedge clk); #1;
            calcu7 = 1'($urandom % 2);
            ready7 = ($urandom % 3) != 0;
        end

        // Zero seed load mid-word enters FAULT.
        @(posedge clk); #1;
        plen_before = plen7;
        calcu7 = 1'b1; ready7 = 1'b1; load7 = 1'b1; seed7 = 7'h00; q7.delete();
        @(posedge clk); #1 load7 = 1'b0;
        @(negedge clk);
        check("fault_valid_cleared", valid7, 0);
        check("fault_lock_err", lock7, 1);
        flag = 1;
        repeat (20) begin
            @(negedge clk);
            if (valid7 !== 1'b0 || lock7 !== 1'b1) flag = 0;
        end
        check("fault_frozen", flag, 1);
        check("fault_period_len_held", plen7, plen_before);
        @(posedge clk); #1;
        load7 = 1'b1; seed7 = 7'h01; refill7(1);
        @(posedge clk); #1 load7 = 1'b0;
        @(negedge clk);
        check("recover_lock_err", lock7, 0);
        cyc = 0;
        for (int i = 0; i < 20 && !valid7; i++) begin
            @(negedge clk);
            cyc++;
        end
        check("recover_first_word_cycle", cyc, 8);
        check("recover_first_word", data7, 8'h02);
        repeat (200) begin
            @(posedge clk); #1;
            calcu7 = 1'($urandom % 2);
            ready7 = ($urandom % 4) != 0;
        end
        calcu7 = 1'b0;

        // ORDER=15, 64-bit words, randomized stepping and back-pressure.
        @(posedge clk); #1;
        refill15(1);
        rst_n15 = 1'b1;
        wrapped = 0;
        for (int c = 0; c < 70000 && wrapped == 0; c++) begin
            @(posedge clk); #1;
            calcu15 = ($urandom % 8) != 0;
            ready15 = ($urandom % 4) != 0;
            @(negedge clk);
            if (wrap15) wrapped = 1;
        end
        check("o15_wrap_seen", wrapped, 1);
        check("o15_period_len", plen15, 32767);

        // Asynchronous reset mid-word with a word pending.
        @(posedge clk); #1;
        ready15 = 1'b0; calcu15 = 1'b1;
        for (int i = 0; i < 200 && !valid15; i++) @(negedge clk);
        repeat (3) @(posedge clk);
        #3 rst_n15 = 1'b0;
        #1;
        check("o15_async_rst_data", data15, 0);
        check("o15_async_rst_valid", valid15, 0);
        check("o15_async_rst_wrap", wrap15, 0);
        check("o15_async_rst_plen", plen15, 0);
        check("o15_async_rst_lock", lock15, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
